// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin arbiter for one memory channel with in-order read response steering.
// Optional MEM_ARB_STATS_EN adds grant/read statistics counters.
package mem_arb_pkg;
    typedef struct packed {
        logic         valid;
        logic         isWrite;
        logic [63:0]  addr;
        logic [511:0] data;
    } mem_req_t;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } mem_resp_t;
endpackage

module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LOG_ORDER_DEPTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  mem_req_t  [1:0]          req_in,
    output logic      [1:0]          req_grant_out,
    output mem_resp_t [1:0]          resp_out,
    input  logic      [1:0]          resp_grant_in,
    output mem_req_t                 mem_req_out,
    input  logic                     mem_req_grant_in,
    input  mem_resp_t                mem_resp_in,
    output logic                     mem_resp_grant_out,
    output logic [LOG_ORDER_DEPTH:0] outstanding,
    output logic                     resp_orphan
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]              stat_grants0,
    output logic [31:0]              stat_grants1,
    output logic [31:0]              stat_reads
`endif
);

    localparam int DEPTH = 2 ** LOG_ORDER_DEPTH;
    localparam logic [LOG_ORDER_DEPTH:0] FULL = (LOG_ORDER_DEPTH + 1)'(DEPTH);

    logic [1:0]                 elig;
    logic                       any_sel;
    logic                       sel;
    logic                       last_granted;
    logic                       granted;
    logic                       do_push;
    logic                       do_pop;
    logic                       fifo_empty;
    logic                       head;
    logic                       order_q [DEPTH];
    logic [LOG_ORDER_DEPTH-1:0] wr_ptr;
    logic [LOG_ORDER_DEPTH-1:0] rd_ptr;

    // Reads are blocked on the registered count only, so a same-cycle pop never frees a slot.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_in[i].valid &&
                      (req_in[i].isWrite || outstanding < FULL);
        end
        any_sel = |elig;
        sel     = (&elig) ? ~last_granted : elig[1];
    end

    always_comb begin
        mem_req_out   = '0;
        req_grant_out = '0;
        if (any_sel) begin
            mem_req_out        = req_in[sel];
            req_grant_out[sel] = mem_req_grant_in;
        end
    end

    assign granted    = any_sel && mem_req_grant_in;
    assign do_push    = granted && !req_in[sel].isWrite;
    assign fifo_empty = (outstanding == '0);
    assign head       = order_q[rd_ptr];

    always_comb begin
        resp_out           = '0;
        mem_resp_grant_out = 1'b0;
        if (mem_resp_in.valid && !fifo_empty) begin
            resp_out[head]     = mem_resp_in;
            mem_resp_grant_out = resp_grant_in[head];
        end
    end

    assign do_pop = mem_resp_grant_out;

    always_ff @(posedge clk) begin
        if (do_push) begin
            order_q[wr_ptr] <= sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_granted <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            outstanding  <= '0;
            resp_orphan  <= 1'b0;
        end else begin
            if (granted) begin
                last_granted <= sel;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                outstanding <= outstanding + 1'b1;
            end else if (!do_push && do_pop) begin
                outstanding <= outstanding - 1'b1;
            end
            if (mem_resp_in.valid && fifo_empty) begin
                resp_orphan <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants0 <= '0;
            stat_grants1 <= '0;
            stat_reads   <= '0;
        end else begin
            if (granted && !sel) begin
                stat_grants0 <= stat_grants0 + 32'd1;
            end
            if (granted && sel) begin
                stat_grants1 <= stat_grants1 + 32'd1;
            end
            if (do_push) begin
                stat_reads <= stat_reads + 32'd1;
            end
        end
    end
`endif

endmodule
